// File: rtl/code2421_up_counter.sv
// ---------------------------------------------------------------------------
// code2421_up_counter
//   Single-digit 2421 (Aiken) code up counter, Moore FSM with ten states
//   S0..S9. Counts 0 -> 9 and wraps. Supports a synchronous parallel load
//   that rejects illegal 2421 words, a binary view of the digit, and a
//   terminal count / carry pair for cascading digits.
//
// Ports
//   clk         in   rising-edge system clock
//   reset       in   asynchronous active-low reset (0 = reset asserted)
//   enable      in   count enable, one step per clock while high
//   load        in   synchronous parallel load request (wins over enable)
//   load_value  in   [3:0] 2421 code word to load
//   count       out  [3:0] current digit in 2421 code (registered)
//   bin         out  [3:0] current digit as binary 0..9 (registered)
//   tc          out  terminal count, high while digit = 9 (registered)
//   carry_out   out  tc & enable (combinational), feeds next digit's enable
//   load_err    out  one-cycle pulse: last load_value was an illegal word
// ---------------------------------------------------------------------------
module code2421_up_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] count,
  output logic [3:0] bin,
  output logic       tc,
  output logic       carry_out,
  output logic       load_err
);

  // State encoding equals the binary digit, so bin is the state itself.
  typedef enum logic [3:0] {
    S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3, S4 = 4'd4,
    S5 = 4'd5, S6 = 4'd6, S7 = 4'd7, S8 = 4'd8, S9 = 4'd9
  } state_t;

  state_t     r_state;
  logic [3:0] r_count;
  logic [3:0] r_bin;
  logic       r_tc;
  logic       r_load_err;

  state_t     w_next_state;
  state_t     w_step_state;
  state_t     w_hold_state;
  state_t     w_load_state;
  logic       w_load_legal;

  // 2421 code word for a digit state.
  function automatic logic [3:0] code_of(input state_t s);
    case (s)
      S0:      code_of = 4'b0000;
      S1:      code_of = 4'b0001;
      S2:      code_of = 4'b0010;
      S3:      code_of = 4'b0011;
      S4:      code_of = 4'b0100;
      S5:      code_of = 4'b1011;
      S6:      code_of = 4'b1100;
      S7:      code_of = 4'b1101;
      S8:      code_of = 4'b1110;
      S9:      code_of = 4'b1111;
      default: code_of = 4'b0000;
    endcase
  endfunction

  // Load decoder: map a 2421 word to its digit state, flag illegal words.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_load_legal = 1'b1;
    w_load_state = S0;
    case (load_value)
      4'b0000: w_load_state = S0;
      4'b0001: w_load_state = S1;
      4'b0010: w_load_state = S2;
      4'b0011: w_load_state = S3;
      4'b0100: w_load_state = S4;
      4'b1011: w_load_state = S5;
      4'b1100: w_load_state = S6;
      4'b1101: w_load_state = S7;
      4'b1110: w_load_state = S8;
      4'b1111: w_load_state = S9;
      default: w_load_legal = 1'b0;  // 0101, 0110, 0111, 1000, 1001, 1010
    endcase
  end

  // Next-state logic. w_hold_state is the "stay here" target; for the
  // unreachable encodings 10..15 it is S0, so every branch (hold, count
  // or rejected load) pulls a corrupted register back to S0 in one edge.
  always_comb begin
    w_step_state = S0;
    w_hold_state = S0;
    case (r_state)
      S0:      begin w_step_state = S1; w_hold_state = S0; end
      S1:      begin w_step_state = S2; w_hold_state = S1; end
      S2:      begin w_step_state = S3; w_hold_state = S2; end
      S3:      begin w_step_state = S4; w_hold_state = S3; end
      S4:      begin w_step_state = S5; w_hold_state = S4; end
      S5:      begin w_step_state = S6; w_hold_state = S5; end
      S6:      begin w_step_state = S7; w_hold_state = S6; end
      S7:      begin w_step_state = S8; w_hold_state = S7; end
      S8:      begin w_step_state = S9; w_hold_state = S8; end
      S9:      begin w_step_state = S0; w_hold_state = S9; end
      default: begin w_step_state = S0; w_hold_state = S0; end
    endcase

    // Load has priority over enable; a rejected load also suppresses the step.
    if (load) begin
      w_next_state = w_load_legal ? w_load_state : w_hold_state;
    end else if (enable) begin
      w_next_state = w_step_state;
    end else begin
      w_next_state = w_hold_state;
    end
  end

  // Outputs are registered from the next state, so they always match the
  // state register and carry no decode glitches.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S0;
      r_count    <= 4'b0000;
      r_bin      <= 4'd0;
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_count    <= code_of(w_next_state);
      r_bin      <= w_next_state;
      r_tc       <= (w_next_state == S9);
      r_load_err <= load & ~w_load_legal;
    end
  end

  assign count     = r_count;
  assign bin       = r_bin;
  assign tc        = r_tc;
  assign load_err  = r_load_err;
  assign carry_out = r_tc & enable;

endmodule

// File: tb/tb_code2421_up_counter.sv
// ---------------------------------------------------------------------------
// tb_code2421_up_counter
//   Directed vectors with hand-computed expectations. The stimulus process
//   drives inputs on the falling edge and pushes the expected post-edge
//   outputs into a queue; the monitor pops one entry 2 time units after
//   each rising edge (or after an explicit mid-cycle check event) and
//   compares every output.
// ---------------------------------------------------------------------------
module tb_code2421_up_counter;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] count;
  logic [3:0] bin;
  logic       tc;
  logic       carry_out;
  logic       load_err;

  typedef struct {
    string      name;
    logic [3:0] count;
    logic [3:0] bin;
    logic       tc;
    logic       co;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  event chk_ev;

  code2421_up_counter dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .bin        (bin),
    .tc         (tc),
    .carry_out  (carry_out),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one queue entry per rising edge or per explicit check event.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, ".count"},     count,             e.count);
        check({e.name, ".bin"},       bin,               e.bin);
        check({e.name, ".tc"},        {3'b000, tc},        {3'b000, e.tc});
        check({e.name, ".carry_out"}, {3'b000, carry_out}, {3'b000, e.co});
        check({e.name, ".load_err"},  {3'b000, load_err},  {3'b000, e.err});
      end
    end
  end

  task automatic push(input string name, input logic [3:0] c, input logic [3:0] b,
                      input logic t, input logic co, input logic err);
    exp_t e;
    e.name = name; e.count = c; e.bin = b; e.tc = t; e.co = co; e.err = err;
    q.push_back(e);
  endtask

  // One clock of stimulus plus the outputs expected after the next rising edge.
  task automatic step(input string name, input logic rst, input logic en, input logic ld,
                      input logic [3:0] lv, input logic [3:0] c, input logic [3:0] b,
                      input logic t, input logic co, input logic err);
    @(negedge clk);
    reset      = rst;
    enable     = en;
    load       = ld;
    load_value = lv;
    push(name, c, b, t, co, err);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; load = 1'b0; load_value = 4'b0000;

    // Reset held low with enable high: everything stays at reset values.
    step("rst0", 0, 1, 0, 4'b0000, 4'b0000, 4'd0, 0, 0, 0);
    step("rst1", 0, 1, 0, 4'b0000, 4'b0000, 4'd0, 0, 0, 0);

    // Full count and wrap.
    step("cnt1", 1, 1, 0, 4'b0000, 4'b0001, 4'd1, 0, 0, 0);
    step("cnt2", 1, 1, 0, 4'b0000, 4'b0010, 4'd2, 0, 0, 0);
    step("cnt3", 1, 1, 0, 4'b0000, 4'b0011, 4'd3, 0, 0, 0);
    step("cnt4", 1, 1, 0, 4'b0000, 4'b0100, 4'd4, 0, 0, 0);
    step("cnt5", 1, 1, 0, 4'b0000, 4'b1011, 4'd5, 0, 0, 0);
    step("cnt6", 1, 1, 0, 4'b0000, 4'b1100, 4'd6, 0, 0, 0);
    step("cnt7", 1, 1, 0, 4'b0000, 4'b1101, 4'd7, 0, 0, 0);
    step("cnt8", 1, 1, 0, 4'b0000, 4'b1110, 4'd8, 0, 0, 0);
    step("cnt9", 1, 1, 0, 4'b0000, 4'b1111, 4'd9, 1, 1, 0);
    step("wrap", 1, 1, 0, 4'b0000, 4'b0000, 4'd0, 0, 0, 0);

    // Count to 5, then hold with enable low.
    step("up1",  1, 1, 0, 4'b0000, 4'b0001, 4'd1, 0, 0, 0);
    step("up2",  1, 1, 0, 4'b0000, 4'b0010, 4'd2, 0, 0, 0);
    step("up3",  1, 1, 0, 4'b0000, 4'b0011, 4'd3, 0, 0, 0);
    step("up4",  1, 1, 0, 4'b0000, 4'b0100, 4'd4, 0, 0, 0);
    step("up5",  1, 1, 0, 4'b0000, 4'b1011, 4'd5, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step("hold", 1, 0, 0, 4'b0000, 4'b1011, 4'd5, 0, 0, 0);
    step("resume", 1, 1, 0, 4'b0000, 4'b1100, 4'd6, 0, 0, 0);

    // Legal load wins over enable, then counting continues from the load.
    step("load7",  1, 1, 1, 4'b1101, 4'b1101, 4'd7, 0, 0, 0);
    step("after7", 1, 1, 0, 4'b0000, 4'b1110, 4'd8, 0, 0, 0);
    step("to9",    1, 1, 0, 4'b0000, 4'b1111, 4'd9, 1, 1, 0);
    step("wrap2",  1, 1, 0, 4'b0000, 4'b0000, 4'd0, 0, 0, 0);
    step("to1",    1, 1, 0, 4'b0000, 4'b0001, 4'd1, 0, 0, 0);
    step("to2",    1, 1, 0, 4'b0000, 4'b0010, 4'd2, 0, 0, 0);
    step("to3",    1, 1, 0, 4'b0000, 4'b0011, 4'd3, 0, 0, 0);

    // Illegal loads: state held, one-cycle error pulse, load blocks enable.
    step("ill0111", 1, 0, 1, 4'b0111, 4'b0011, 4'd3, 0, 0, 1);
    step("errclr",  1, 0, 0, 4'b0000, 4'b0011, 4'd3, 0, 0, 0);
    step("ill1000", 1, 1, 1, 4'b1000, 4'b0011, 4'd3, 0, 0, 1);
    step("ill1010", 1, 0, 1, 4'b1010, 4'b0011, 4'd3, 0, 0, 1);
    step("load0",   1, 0, 1, 4'b0000, 4'b0000, 4'd0, 0, 0, 0);
    step("load9a",  1, 0, 1, 4'b1111, 4'b1111, 4'd9, 1, 0, 0);
    step("load9b",  1, 1, 1, 4'b1111, 4'b1111, 4'd9, 1, 1, 0);

    // Asynchronous reset pulse between edges while in S9 with enable high.
    @(negedge clk);
    load = 1'b0; enable = 1'b1;
    #1 reset = 1'b0;
    push("async", 4'b0000, 4'd0, 0, 0, 0);
    ->chk_ev;
    #3 reset = 1'b1;
    push("post1", 4'b0001, 4'd1, 0, 0, 0);
    step("post2", 1, 1, 0, 4'b0000, 4'b0010, 4'd2, 0, 0, 0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code2421_up_counter.md
# code2421_up_counter

Single-digit 2421 (Aiken) code up counter built as a Moore FSM with a case-structured next-state block. It is the counting-direction complement of the team's 2421 down counter: same code table, same clock/reset/enable scheme, counting 0 → 9 and wrapping. It adds a synchronous parallel load with illegal-code rejection, a binary-decoded output and a carry output, so multiple digits can be cascaded into a multi-digit 2421 counter.

## Interface
- No parameters; width is fixed by the 2421 code at 4 bits.
- clk  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  count enable; advances one state per clock when high.
- load  input  1  synchronous parallel load request.
- load_value  input  4  2421 code word to load.
- count  output  4  current digit in 2421 code, registered.
- bin  output  4  current digit as unsigned binary 0–9, registered.
- tc  output  1  terminal count, registered; high while digit = 9.
- carry_out  output  1  combinational: tc & enable; drives the next digit's enable.
- load_err  output  1  registered one-cycle pulse; load_value was an illegal 2421 code.

## Operation
- Code table (digit: count): 0:0000, 1:0001, 2:0010, 3:0011, 4:0100, 5:1011, 6:1100, 7:1101, 8:1110, 9:1111.
- Illegal 2421 words: 0101, 0110, 0111, 1000, 1001, 1010.
- FSM has ten states S0–S9, one per digit, in a 4-bit state register; all outputs except carry_out decode from state only (Moore).
- Transitions evaluated at each rising clk edge, in this priority:
  - reset low: state ← S0 asynchronously; overrides everything.
  - load high, legal load_value: state ← digit of load_value; load_err ← 0.
  - load high, illegal load_value: state unchanged; load_err ← 1 for exactly one cycle.
  - load low, enable high: state ← next digit; S9 → S0 (wrap).
  - load low, enable low: state held.
- Load wins over enable when both are high in the same cycle; no count step occurs in that cycle.
- load_err returns to 0 on the next edge unless another illegal load is presented.
- Unreachable state encodings (10–15) must recover to S0 on the next edge (default branch). They are not reachable in normal operation.
- Cascading: a digit's carry_out feeds the next digit's enable; both digits share clk, reset and load.

## Timing
- Reset values: count = 0000, bin = 0000, tc = 0, load_err = 0, carry_out = 0.
- Reset assertion takes effect immediately, without waiting for clk. Deassertion is sampled at the next rising edge, and the first count step happens on that edge if enable is high.
- Count latency: count, bin and tc update on the same rising edge that samples enable = 1, visible 1 cycle after enable is applied.
- Load latency: 1 cycle from load assertion to the new count/bin.
- tc is high for the entire cycle in which the state is S9. carry_out follows enable combinationally within that cycle.
- Reset mid-count, including in S9: outputs go to reset values immediately, and carry_out drops with tc.
- Count sequence with continuous enable has period 10 clocks; carry_out pulses high for 1 of every 10 clocks.

## Test plan
- Reset: hold reset = 0 for 2 clocks with enable = 1 → count = 0000, bin = 0, tc = 0, load_err = 0 throughout.
- Full count and wrap: reset high, enable = 1 for 11 clocks → count steps through 0000, 0001, 0010, 0011, 0100, 1011, 1100, 1101, 1110, 1111, 0000. bin steps 0..9 then 0. tc and carry_out are high only while count = 1111.
- Hold: at count = 1011 (digit 5), drop enable for 5 clocks → count stays 1011 and carry_out = 0. Raise enable → next edge gives 1100.
- Valid load with priority: load = 1, enable = 1, load_value = 1101 → next edge count = 1101, bin = 7, no extra step. Release load with enable = 1 → next edge count = 1110.
- Illegal load: from count = 0011, load = 1, load_value = 0111 for one clock → count stays 0011 and load_err = 1 for exactly one cycle, then 0.
- Asynchronous reset mid-operation: at count = 1111 with enable = 1, pulse reset low between clock edges → count = 0000 and tc = carry_out = 0 before the next edge. After release, counting resumes 0001, 0010, ….
